// File: rtl/pc_pkg.sv
// pc_pkg: next-PC select encodings and PC increment shared by the PC sequencer.
package pc_pkg;
  localparam logic [2:0] PS_HOLD     = 3'b000;
  localparam logic [2:0] PS_INC      = 3'b001;
  localparam logic [2:0] PS_ABS      = 3'b010;
  localparam logic [2:0] PS_REL      = 3'b011;
  localparam logic [2:0] PS_CALL_REL = 3'b100;
  localparam logic [2:0] PS_RET      = 3'b101;
  localparam logic [2:0] PS_CALL_ABS = 3'b110;
  localparam int PC_INC = 4;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int WIDTH     = 64,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  assign full      = cnt_q == CW'(RAS_DEPTH);
  assign empty     = cnt_q == '0;
  assign top       = mem_q[ptr_q];
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  // When full, top+1 wraps onto the oldest slot, so overwrite falls out naturally.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (push) begin
      ptr_d = ptr_q + PW'(1);
      cnt_d = full ? cnt_q : cnt_q + CW'(1);
      ovf_d = full;
    end else if (pop) begin
      ptr_d = empty ? ptr_q : ptr_q - PW'(1);
      cnt_d = empty ? cnt_q : cnt_q - CW'(1);
      unf_d = empty;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem_q[ptr_d] <= push_data;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register with next-PC select, stall, and a return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 64,
  parameter int               RAS_DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             stall,
  input  logic [2:0]       PS,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC4,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_underflow,
  output logic             ras_overflow
);
  logic [WIDTH-1:0] pc_q, pc_d, rel, ras_top;
  logic             push, pop;
  assign PC  = pc_q;
  assign PC4 = pc_q + WIDTH'(PC_INC);
  assign rel = PC4 + (in << 2);
  // Stall suppresses push/pop so the stack and its pulses stay quiet too.
  always_comb begin
    pc_d = pc_q;
    push = 1'b0;
    pop  = 1'b0;
    if (!stall) begin
      case (PS)
        PS_INC:      pc_d = PC4;
        PS_ABS:      pc_d = in;
        PS_REL:      pc_d = rel;
        PS_CALL_REL: begin pc_d = rel; push = 1'b1; end
        PS_RET:      begin pc_d = ras_empty ? PC4 : ras_top; pop = 1'b1; end
        PS_CALL_ABS: begin pc_d = in; push = 1'b1; end
        default:     pc_d = pc_q;
      endcase
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pc_q <= RESET_VECTOR;
    else          pc_q <= pc_d;
  end
  ras_stack #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .push_data (PC4),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenario tasks for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;
  localparam logic [2:0] HOLD = 3'b000, INC = 3'b001, ABS = 3'b010, REL = 3'b011;
  localparam logic [2:0] CALL_REL = 3'b100, RET = 3'b101, CALL_ABS = 3'b110;
  logic        clock = 0, reset_n = 0, stall = 0;
  logic [2:0]  ps = INC;
  logic [63:0] in_v = '0;
  logic [63:0] pc, pc4;
  logic        ras_empty, ras_full, ras_underflow, ras_overflow;
  int tests = 0, fails = 0;

  pc_sequencer #(.WIDTH(64), .RAS_DEPTH(4), .RESET_VECTOR(64'h100)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .PS(ps), .in(in_v),
    .PC(pc), .PC4(pc4), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_underflow(ras_underflow), .ras_overflow(ras_overflow)
  );

  always #5 clock = ~clock;

  task automatic cyc(input logic [2:0] p, input logic [63:0] v);
    ps = p;
    in_v = v;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    #12;
    tests++; if (pc !== 64'h100) begin fails++; $display("FAIL reset_pc: got %h want %h", pc, 64'h100); end
    tests++; if (pc4 !== 64'h104) begin fails++; $display("FAIL reset_pc4: got %h want %h", pc4, 64'h104); end
    tests++; if ({ras_empty, ras_full, ras_underflow, ras_overflow} !== 4'b1000) begin
      fails++; $display("FAIL reset_flags: got %b want 1000", {ras_empty, ras_full, ras_underflow, ras_overflow}); end
    @(negedge clock);
    reset_n = 1;
    for (int i = 1; i <= 3; i++) begin
      cyc(INC, '0);
      tests++; if (pc !== 64'h100 + 64'(4 * i) || ras_empty !== 1'b1) begin
        fails++; $display("FAIL reset_inc%0d: got pc=%h empty=%b want pc=%h empty=1", i, pc, ras_empty, 64'h100 + 64'(4 * i)); end
    end
  endtask

  task automatic test_stall;
    cyc(ABS, 64'h10);
    stall = 1;
    cyc(INC, '0);
    cyc(INC, '0);
    tests++; if (pc !== 64'h10) begin fails++; $display("FAIL stall_hold: got %h want %h", pc, 64'h10); end
    stall = 0;
    cyc(INC, '0);
    tests++; if (pc !== 64'h14) begin fails++; $display("FAIL stall_release: got %h want %h", pc, 64'h14); end
    stall = 1;
    cyc(CALL_ABS, 64'h500);
    stall = 0;
    tests++; if (pc !== 64'h14 || ras_empty !== 1'b1 || ras_overflow !== 1'b0) begin
      fails++; $display("FAIL stall_call: got pc=%h empty=%b ovf=%b want pc=14 empty=1 ovf=0", pc, ras_empty, ras_overflow); end
  endtask

  task automatic test_branches;
    cyc(ABS, 64'h20);
    cyc(REL, 64'hFFFF_FFFF_FFFF_FFFE);
    tests++; if (pc !== 64'h1C) begin fails++; $display("FAIL rel_neg: got %h want %h", pc, 64'h1C); end
    cyc(ABS, 64'hFFFF_FFFF_FFFF_FFFC);
    tests++; if (pc4 !== 64'h0) begin fails++; $display("FAIL pc4_wrap: got %h want %h", pc4, 64'h0); end
    cyc(INC, '0);
    tests++; if (pc !== 64'h0) begin fails++; $display("FAIL inc_wrap: got %h want %h", pc, 64'h0); end
    cyc(REL, 64'hC000_0000_0000_0001);
    tests++; if (pc !== 64'h8) begin fails++; $display("FAIL rel_shift_drop: got %h want %h", pc, 64'h8); end
    cyc(4'd7, 64'h1234);
    tests++; if (pc !== 64'h8) begin fails++; $display("FAIL reserved_hold: got %h want %h", pc, 64'h8); end
  endtask

  task automatic test_nested;
    cyc(ABS, 64'h40);
    cyc(CALL_ABS, 64'h1000);
    tests++; if (pc !== 64'h1000 || ras_empty !== 1'b0) begin
      fails++; $display("FAIL call1: got pc=%h empty=%b want pc=1000 empty=0", pc, ras_empty); end
    cyc(CALL_ABS, 64'h2000);
    tests++; if (pc !== 64'h2000) begin fails++; $display("FAIL call2: got %h want %h", pc, 64'h2000); end
    cyc(RET, '0);
    tests++; if (pc !== 64'h1004) begin fails++; $display("FAIL ret1: got %h want %h", pc, 64'h1004); end
    cyc(RET, '0);
    tests++; if (pc !== 64'h44 || ras_empty !== 1'b1) begin
      fails++; $display("FAIL ret2: got pc=%h empty=%b want pc=44 empty=1", pc, ras_empty); end
  endtask

  task automatic test_overflow;
    logic [63:0] exp;
    cyc(ABS, 64'h100);
    cyc(CALL_REL, 64'h3F);
    tests++; if (pc !== 64'h200 || ras_overflow !== 1'b0) begin
      fails++; $display("FAIL call_rel: got pc=%h ovf=%b want pc=200 ovf=0", pc, ras_overflow); end
    for (int i = 3; i <= 5; i++) cyc(CALL_ABS, 64'(i) << 8);
    tests++; if (ras_full !== 1'b1 || ras_overflow !== 1'b0) begin
      fails++; $display("FAIL full_no_ovf: got full=%b ovf=%b want full=1 ovf=0", ras_full, ras_overflow); end
    cyc(CALL_ABS, 64'h600);
    tests++; if (ras_overflow !== 1'b1 || ras_full !== 1'b1 || pc !== 64'h600) begin
      fails++; $display("FAIL overflow_pulse: got ovf=%b full=%b pc=%h want ovf=1 full=1 pc=600", ras_overflow, ras_full, pc); end
    for (int i = 5; i >= 2; i--) begin
      cyc(RET, '0);
      exp = (64'(i) << 8) + 64'h4;
      tests++; if (pc !== exp || ras_overflow !== 1'b0) begin
        fails++; $display("FAIL ovf_ret%0d: got pc=%h ovf=%b want pc=%h ovf=0", i, pc, ras_overflow, exp); end
    end
    tests++; if (ras_empty !== 1'b1) begin fails++; $display("FAIL ovf_empty: got %b want 1", ras_empty); end
  endtask

  task automatic test_underflow;
    cyc(ABS, 64'h80);
    cyc(RET, '0);
    tests++; if (pc !== 64'h84 || ras_underflow !== 1'b1 || ras_empty !== 1'b1) begin
      fails++; $display("FAIL underflow: got pc=%h unf=%b empty=%b want pc=84 unf=1 empty=1", pc, ras_underflow, ras_empty); end
    cyc(HOLD, '0);
    tests++; if (pc !== 64'h84 || ras_underflow !== 1'b0) begin
      fails++; $display("FAIL underflow_one_cycle: got pc=%h unf=%b want pc=84 unf=0", pc, ras_underflow); end
  endtask

  task automatic test_async_reset;
    cyc(CALL_ABS, 64'h900);
    cyc(CALL_ABS, 64'hA00);
    tests++; if (ras_empty !== 1'b0 || pc !== 64'hA00) begin
      fails++; $display("FAIL pre_reset: got pc=%h empty=%b want pc=a00 empty=0", pc, ras_empty); end
    ps = CALL_ABS;
    in_v = 64'hB00;
    #2;
    reset_n = 0;
    #1;
    tests++; if (pc !== 64'h100 || ras_empty !== 1'b1) begin
      fails++; $display("FAIL async_reset: got pc=%h empty=%b want pc=100 empty=1", pc, ras_empty); end
    @(posedge clock);
    #1;
    tests++; if (pc !== 64'h100 || ras_empty !== 1'b1) begin
      fails++; $display("FAIL reset_held: got pc=%h empty=%b want pc=100 empty=1", pc, ras_empty); end
    @(negedge clock);
    reset_n = 1;
    cyc(RET, '0);
    tests++; if (pc !== 64'h104 || ras_underflow !== 1'b1) begin
      fails++; $display("FAIL post_reset_ret: got pc=%h unf=%b want pc=104 unf=1", pc, ras_underflow); end
  endtask

  initial begin
    test_reset;
    test_stall;
    test_branches;
    test_nested;
    test_overflow;
    test_underflow;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
